cmd_mreq_exec: RTL and testbench

Executes decoded memory requests from the command receiver on a 32-bit Wishbone-classic master bus. MWRITE data bytes are pulled from the receiver's rx byte stream and packed into bus words; MREAD results are serialized onto a tx byte stream toward the response path. The block sits directly downstream of the command receiver. Completion is reported with a one-cycle ready pulse.

---
 rtl/cmd_mreq_exec.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_cmd_mreq_exec.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_mreq_exec.sv
// cmd_mreq_exec
// Executes one decoded memory request (MWRITE / MREAD) from the command
// receiver as a sequence of Wishbone-classic single transfers.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_mreq_*                : request handshake and fields, sampled in IDLE only
//   o_mreq_ready            : one-cycle pulse when the request has fully completed
//   i_rx_* / o_rx_ready     : write-data byte stream, consumed lowest lane first
//   o_tx_* / i_tx_ready     : read-data byte stream, produced lowest lane first
//   o_wb_* / i_wb_*         : Wishbone-classic master (word addressed)
//   o_err_timeout           : sticky, set when any transfer of the request timed out
// All outputs come straight from flops. Each output register is loaded from
// the next-state value, so it changes in the same cycle as the state.
module cmd_mreq_exec #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mreq_valid,
    output logic        o_mreq_ready,
    input  logic        i_mreq_wr,
    input  logic [1:0]  i_mreq_wsize,
    input  logic        i_mreq_aincr,
    input  logic [7:0]  i_mreq_size,
    input  logic [31:0] i_mreq_addr,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    output logic        o_err_timeout
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WR_GATHER = 3'd1;
    localparam logic [2:0] ST_WR_BUS    = 3'd2;
    localparam logic [2:0] ST_RD_BUS    = 3'd3;
    localparam logic [2:0] ST_RD_SEND   = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    // Counter value on the TIMEOUT-th stb cycle without ack.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    // Lowest byte lane of a word of size ws at byte offset a.
    function automatic logic [1:0] lane_base(input logic [1:0] ws, input logic [1:0] a);
        logic [1:0] b;
        case (ws)
            2'd0:    b = a;
            2'd1:    b = {a[1], 1'b0};
            default: b = 2'd0;
        endcase
        return b;
    endfunction

    // Index of the last byte within a word (byte count minus one).
    function automatic logic [1:0] last_idx(input logic [1:0] ws);
        logic [1:0] l;
        case (ws)
            2'd0:    l = 2'd0;
            2'd1:    l = 2'd1;
            default: l = 2'd3;
        endcase
        return l;
    endfunction

    // Byte-lane enables for a word of size ws at byte offset a.
    function automatic logic [3:0] lane_sel(input logic [1:0] ws, input logic [1:0] a);
        logic [3:0] s;
        case (ws)
            2'd0:    s = 4'b0001 << a;
            2'd1:    s = a[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Captured request; wsize_r is normalised so that 3 never appears.
    logic [2:0]  state_r,    state_s;
    logic        wr_r,       wr_s;
    logic [1:0]  wsize_r,    wsize_s;
    logic        aincr_r,    aincr_s;
    logic [7:0]  size_r,     size_s;
    logic [31:0] addr_r,     addr_s;
    logic [7:0]  word_cnt_r, word_cnt_s;
    logic [1:0]  byte_idx_r, byte_idx_s;
    logic [31:0] data_r,     data_s;
    logic [15:0] tmo_cnt_r,  tmo_cnt_s;
    logic        err_r,      err_s;

    logic        stb_r,      stb_s;
    logic        we_r,       we_s;
    logic [3:0]  sel_r,      sel_s;
    logic        rx_ready_r, rx_ready_s;
    logic        tx_valid_r, tx_valid_s;
    logic [7:0]  tx_data_r,  tx_data_s;
    logic        ready_r,    ready_s;

    logic [1:0]  lane_s;
    logic [1:0]  out_lane_s;
    logic        last_byte_s;
    logic        last_word_s;
    logic        tmo_hit_s;
    logic        next_word_s;
    logic [31:0] step_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_s     = state_r;
        wr_s        = wr_r;
        wsize_s     = wsize_r;
        aincr_s     = aincr_r;
        size_s      = size_r;
        addr_s      = addr_r;
        word_cnt_s  = word_cnt_r;
        byte_idx_s  = byte_idx_r;
        data_s      = data_r;
        tmo_cnt_s   = tmo_cnt_r;
        err_s       = err_r;
        next_word_s = 1'b0;

        lane_s      = lane_base(wsize_r, addr_r[1:0]) + byte_idx_r;
        last_byte_s = (byte_idx_r == last_idx(wsize_r));
        last_word_s = (word_cnt_r == size_r);
        tmo_hit_s   = (tmo_cnt_r == TMO_LAST);
        step_s      = aincr_r ? (32'd1 << wsize_r) : 32'd0;

        case (state_r)
            ST_IDLE: begin
                if (i_mreq_valid) begin
                    wr_s       = i_mreq_wr;
                    wsize_s    = (i_mreq_wsize == 2'd3) ? 2'd2 : i_mreq_wsize;
                    aincr_s    = i_mreq_aincr;
                    size_s     = i_mreq_size;
                    addr_s     = i_mreq_addr;
                    word_cnt_s = 8'd0;
                    byte_idx_s = 2'd0;
                    data_s     = 32'd0;
                    tmo_cnt_s  = 16'd0;
                    err_s      = 1'b0;
                    state_s    = i_mreq_wr ? ST_WR_GATHER : ST_RD_BUS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_GATHER: begin
                if (i_rx_valid && rx_ready_r) begin
                    data_s[{lane_s, 3'b000} +: 8] = i_rx_data;
                    if (last_byte_s) begin
                        byte_idx_s = 2'd0;
                        tmo_cnt_s  = 16'd0;
                        state_s    = ST_WR_BUS;
                    end else begin
                        byte_idx_s = byte_idx_r + 2'd1;
                    end
                end else begin
                    state_s = ST_WR_GATHER;
                end
            end
            ST_WR_BUS: begin
                // A timed-out write is dropped but still counts as a word.
                if (i_wb_ack) begin
                    next_word_s = 1'b1;
                end else if (tmo_hit_s) begin
                    err_s       = 1'b1;
                    next_word_s = 1'b1;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 16'd1;
                end
            end
            ST_RD_BUS: begin
                // A timed-out read still streams out its bytes, as zeros.
                if (i_wb_ack) begin
                    data_s     = i_wb_dat;
                    byte_idx_s = 2'd0;
                    state_s    = ST_RD_SEND;
                end else if (tmo_hit_s) begin
                    data_s     = 32'd0;
                    err_s      = 1'b1;
                    byte_idx_s = 2'd0;
                    state_s    = ST_RD_SEND;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 16'd1;
                end
            end
            ST_RD_SEND: begin
                if (tx_valid_r && i_tx_ready) begin
                    if (last_byte_s) begin
                        next_word_s = 1'b1;
                    end else begin
                        byte_idx_s = byte_idx_r + 2'd1;
                    end
                end else begin
                    state_s = ST_RD_SEND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Word finished: either close the request or set up the next word.
        if (next_word_s) begin
            byte_idx_s = 2'd0;
            tmo_cnt_s  = 16'd0;
            if (last_word_s) begin
                state_s = ST_DONE;
            end else begin
                word_cnt_s = word_cnt_r + 8'd1;
                addr_s     = addr_r + step_s;
                data_s     = 32'd0;
                state_s    = wr_r ? ST_WR_GATHER : ST_RD_BUS;
            end
        end else begin
            state_s = state_s;
        end

        out_lane_s = lane_base(wsize_s, addr_s[1:0]) + byte_idx_s;
        stb_s      = (state_s == ST_WR_BUS) || (state_s == ST_RD_BUS);
        we_s       = (state_s == ST_WR_BUS);
        sel_s      = stb_s ? lane_sel(wsize_s, addr_s[1:0]) : 4'd0;
        rx_ready_s = (state_s == ST_WR_GATHER);
        tx_valid_s = (state_s == ST_RD_SEND);
        tx_data_s  = tx_valid_s ? data_s[{out_lane_s, 3'b000} +: 8] : 8'd0;
        ready_s    = (state_s == ST_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            wr_r       <= 1'b0;
            wsize_r    <= 2'd0;
            aincr_r    <= 1'b0;
            size_r     <= 8'd0;
            addr_r     <= 32'd0;
            word_cnt_r <= 8'd0;
            byte_idx_r <= 2'd0;
            data_r     <= 32'd0;
            tmo_cnt_r  <= 16'd0;
            err_r      <= 1'b0;
            stb_r      <= 1'b0;
            we_r       <= 1'b0;
            sel_r      <= 4'd0;
            rx_ready_r <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'd0;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            wr_r       <= wr_s;
            wsize_r    <= wsize_s;
            aincr_r    <= aincr_s;
            size_r     <= size_s;
            addr_r     <= addr_s;
            word_cnt_r <= word_cnt_s;
            byte_idx_r <= byte_idx_s;
            data_r     <= data_s;
            tmo_cnt_r  <= tmo_cnt_s;
            err_r      <= err_s;
            stb_r      <= stb_s;
            we_r       <= we_s;
            sel_r      <= sel_s;
            rx_ready_r <= rx_ready_s;
            tx_valid_r <= tx_valid_s;
            tx_data_r  <= tx_data_s;
            ready_r    <= ready_s;
        end
    end

    assign o_mreq_ready  = ready_r;
    assign o_rx_ready    = rx_ready_r;
    assign o_tx_valid    = tx_valid_r;
    assign o_tx_data     = tx_data_r;
    assign o_wb_cyc      = stb_r;
    assign o_wb_stb      = stb_r;
    assign o_wb_we       = we_r;
    assign o_wb_adr      = addr_r[31:2];
    assign o_wb_dat      = data_r;
    assign o_wb_sel      = sel_r;
    assign o_err_timeout = err_r;

endmodule

// File: tb/tb_cmd_mreq_exec.sv
// Testbench for cmd_mreq_exec: table of directed requests run through a
// cycle-level driver (bus slave, rx source, tx sink), plus a hand-written
// address-wrap / mid-transfer reset sequence.
module tb_cmd_mreq_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        mreq_valid, mreq_ready, mreq_wr, mreq_aincr;
    logic [1:0]  mreq_wsize;
    logic [7:0]  mreq_size;
    logic [31:0] mreq_addr;
    logic        rx_valid, rx_ready, tx_valid, tx_ready;
    logic [7:0]  rx_data, tx_data;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, err_timeout;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    cmd_mreq_exec #(.TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_mreq_valid(mreq_valid), .o_mreq_ready(mreq_ready),
        .i_mreq_wr(mreq_wr), .i_mreq_wsize(mreq_wsize), .i_mreq_aincr(mreq_aincr),
        .i_mreq_size(mreq_size), .i_mreq_addr(mreq_addr),
        .i_rx_valid(rx_valid), .i_rx_data(rx_data), .o_rx_ready(rx_ready),
        .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat_o), .o_wb_sel(wb_sel),
        .i_wb_dat(wb_dat_i), .i_wb_ack(wb_ack), .o_err_timeout(err_timeout)
    );

    typedef struct {
        string             name;
        logic              wr;
        logic [1:0]        wsize;
        logic              aincr;
        logic [7:0]        size;
        logic [31:0]       addr;
        int                nwords;
        logic [3:0][31:0]  rdata;
        logic [7:0][7:0]   rx;
        logic [3:0][29:0]  exp_adr;
        logic [3:0][3:0]   exp_sel;
        logic [3:0][31:0]  exp_dat;
        logic [7:0][7:0]   exp_tx;
        int                ntx;
        int                stall_at;
        bit                rx_gaps;
        int                ack_delay;
        bit                no_ack;
        int                exp_stb;
        logic              exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int nb(input logic [1:0] ws);
        if (ws == 2'd0) return 1;
        else if (ws == 2'd1) return 2;
        else return 4;
    endfunction

    function automatic vec_t blank(input string nm);
        vec_t v;
        v.name = nm; v.wr = 1'b0; v.wsize = 2'd0; v.aincr = 1'b0; v.size = 8'd0;
        v.addr = 32'd0; v.nwords = 1; v.rdata = '0; v.rx = '0; v.exp_adr = '0;
        v.exp_sel = '0; v.exp_dat = '0; v.exp_tx = '0; v.ntx = 0; v.stall_at = -1;
        v.rx_gaps = 1'b0; v.ack_delay = 0; v.no_ack = 1'b0; v.exp_stb = 1; v.exp_err = 1'b0;
        return v;
    endfunction

    function automatic logic [7:0] rxb(input vec_t v, input int i);
        logic [31:0] iv;
        iv = 32'(i);
        return (i < 8) ? v.rx[i] : iv[7:0];
    endfunction

    task automatic run_vec(input vec_t v);
        int words = 0, stb_cyc = 0, rx_i = 0, tx_i = 0, readies = 0, post = 0;
        int stall_left = 0, nbv, nrx, w;
        bit stalled = 0, pend_stb = 0, seen_ready = 0;
        logic prev_stb = 1'b0;
        logic [7:0] held = 8'd0;
        logic [31:0] mask;
        nbv = nb(v.wsize);
        nrx = v.wr ? v.nwords * nbv : 0;
        @(negedge clk);
        mreq_valid = 1'b1; mreq_wr = v.wr; mreq_wsize = v.wsize; mreq_aincr = v.aincr;
        mreq_size = v.size; mreq_addr = v.addr;
        @(negedge clk);
        // Fields change after capture; the DUT must ignore them.
        mreq_valid = 1'b0; mreq_wr = ~v.wr; mreq_wsize = ~v.wsize; mreq_aincr = ~v.aincr;
        mreq_size = 8'h5A; mreq_addr = ~v.addr;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 0) begin
                chk({v.name, " capture"}, 32'(v.wr ? rx_ready : wb_stb), 32'd1);
                chk({v.name, " err_clr"}, 32'(err_timeout), 32'd0);
            end
            if (pend_stb) begin
                chk({v.name, " wr_stb_rise"}, 32'(wb_stb), 32'd1);
                pend_stb = 0;
            end
            if (wb_stb && !prev_stb) begin
                w = words; words++; stb_cyc = 0;
                if (w < 4) begin
                    chk({v.name, " adr"}, 32'(wb_adr), 32'(v.exp_adr[w]));
                    chk({v.name, " sel"}, 32'(wb_sel), 32'(v.exp_sel[w]));
                    chk({v.name, " we"}, 32'(wb_we), 32'(v.wr));
                    chk({v.name, " cyc"}, 32'(wb_cyc), 32'd1);
                    if (v.wr) begin
                        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{v.exp_sel[w][b]}};
                        chk({v.name, " dat"}, wb_dat_o & mask, v.exp_dat[w] & mask);
                    end
                end
            end
            if (!wb_stb && prev_stb) begin
                chk({v.name, " stb_cycles"}, 32'(stb_cyc), 32'(v.exp_stb));
                if (v.wr) chk({v.name, " after_wr_ack"}, 32'(words < v.nwords ? rx_ready : mreq_ready), 32'd1);
                else      chk({v.name, " tx_after_ack"}, 32'(tx_valid), 32'd1);
            end
            if (wb_stb) stb_cyc++;
            prev_stb = wb_stb;
            wb_ack   = wb_stb && !v.no_ack && (stb_cyc > v.ack_delay);
            wb_dat_i = (words >= 1 && words <= 4) ? v.rdata[words-1] : 32'h0;
            // Write-data source.
            if (rx_i < nrx && (!v.rx_gaps || (cyc % 2 == 1))) begin
                rx_valid = 1'b1; rx_data = rxb(v, rx_i);
                if (rx_ready) begin
                    rx_i++;
                    if (rx_i % nbv == 0) pend_stb = 1;
                end
            end else begin
                rx_valid = 1'b0; rx_data = 8'hEE;
            end
            // Read-data sink, with an optional 10-cycle stall.
            if (stall_left > 0 && !tx_valid) begin
                chk({v.name, " tx_valid_stall"}, 32'(tx_valid), 32'd1);
                stall_left = 0;
            end
            tx_ready = 1'b1;
            if (tx_valid) begin
                if (stall_left > 0) begin
                    chk({v.name, " tx_hold"}, 32'(tx_data), 32'(held));
                    tx_ready = 1'b0; stall_left--;
                end else if (tx_i == v.stall_at && !stalled) begin
                    stalled = 1; held = tx_data; stall_left = 9; tx_ready = 1'b0;
                end else begin
                    if (tx_i < v.ntx) chk({v.name, " tx_byte"}, 32'(tx_data), 32'(v.exp_tx[tx_i]));
                    else chk({v.name, " tx_extra"}, 32'(tx_i), 32'(v.ntx));
                    tx_i++;
                end
            end
            if (mreq_ready) begin
                readies++;
                if (!seen_ready) chk({v.name, " ready_after_last"}, 32'(words), 32'(v.nwords));
                seen_ready = 1;
            end
            if (seen_ready) begin
                post++;
                if (post > 4) break;
            end
        end
        rx_valid = 1'b0; wb_ack = 1'b0; tx_ready = 1'b1;
        if (!seen_ready) chk({v.name, " no_ready_timeout"}, 32'd0, 32'd1);
        chk({v.name, " ready_pulses"}, 32'(readies), 32'd1);
        chk({v.name, " words"}, 32'(words), 32'(v.nwords));
        chk({v.name, " rx_bytes"}, 32'(rx_i), 32'(nrx));
        chk({v.name, " tx_bytes"}, 32'(tx_i), 32'(v.ntx));
        chk({v.name, " err"}, 32'(err_timeout), 32'(v.exp_err));
    endtask

    initial begin
        int txn;
        int rdy;
        rst = 1'b1; mreq_valid = 1'b0; mreq_wr = 1'b0; mreq_wsize = 2'd0; mreq_aincr = 1'b0;
        mreq_size = 8'd0; mreq_addr = 32'd0; rx_valid = 1'b0; rx_data = 8'd0;
        tx_ready = 1'b1; wb_ack = 1'b0; wb_dat_i = 32'd0;

        vecs[0] = blank("wr_word"); vecs[0].wr = 1'b1; vecs[0].wsize = 2'd2; vecs[0].addr = 32'h100;
        vecs[0].rx[0] = 8'h11; vecs[0].rx[1] = 8'h22; vecs[0].rx[2] = 8'h33; vecs[0].rx[3] = 8'h44;
        vecs[0].exp_adr[0] = 30'h40; vecs[0].exp_sel[0] = 4'hF; vecs[0].exp_dat[0] = 32'h44332211;

        vecs[1] = blank("rd_bytes"); vecs[1].aincr = 1'b1; vecs[1].size = 8'd2; vecs[1].nwords = 3;
        vecs[1].addr = 32'h203;
        vecs[1].rdata[0] = 32'hAABBCCDD; vecs[1].rdata[1] = 32'h01020304; vecs[1].rdata[2] = 32'h55667788;
        vecs[1].exp_adr[0] = 30'h80; vecs[1].exp_adr[1] = 30'h81; vecs[1].exp_adr[2] = 30'h81;
        vecs[1].exp_sel[0] = 4'h8; vecs[1].exp_sel[1] = 4'h1; vecs[1].exp_sel[2] = 4'h2;
        vecs[1].exp_tx[0] = 8'hAA; vecs[1].exp_tx[1] = 8'h04; vecs[1].exp_tx[2] = 8'h77; vecs[1].ntx = 3;

        vecs[2] = blank("wr_half_gaps"); vecs[2].wr = 1'b1; vecs[2].wsize = 2'd1; vecs[2].size = 8'd1;
        vecs[2].nwords = 2; vecs[2].addr = 32'h12; vecs[2].rx_gaps = 1'b1;
        vecs[2].rx[0] = 8'hA1; vecs[2].rx[1] = 8'hB2; vecs[2].rx[2] = 8'hC3; vecs[2].rx[3] = 8'hD4;
        vecs[2].exp_adr[0] = 30'h4; vecs[2].exp_adr[1] = 30'h4;
        vecs[2].exp_sel[0] = 4'hC; vecs[2].exp_sel[1] = 4'hC;
        vecs[2].exp_dat[0] = 32'hB2A10000; vecs[2].exp_dat[1] = 32'hD4C30000;

        vecs[3] = blank("rd_stall"); vecs[3].wsize = 2'd2; vecs[3].addr = 32'h40; vecs[3].stall_at = 2;
        vecs[3].rdata[0] = 32'hDEADBEEF; vecs[3].exp_adr[0] = 30'h10; vecs[3].exp_sel[0] = 4'hF;
        vecs[3].exp_tx[0] = 8'hEF; vecs[3].exp_tx[1] = 8'hBE; vecs[3].exp_tx[2] = 8'hAD;
        vecs[3].exp_tx[3] = 8'hDE; vecs[3].ntx = 4;

        vecs[4] = blank("rd_timeout"); vecs[4].wsize = 2'd2; vecs[4].addr = 32'h80; vecs[4].no_ack = 1'b1;
        vecs[4].rdata[0] = 32'h12345678; vecs[4].exp_adr[0] = 30'h20; vecs[4].exp_sel[0] = 4'hF;
        vecs[4].ntx = 4; vecs[4].exp_stb = 4; vecs[4].exp_err = 1'b1;

        vecs[5] = blank("wr_late_ack"); vecs[5].wr = 1'b1; vecs[5].aincr = 1'b1; vecs[5].size = 8'd1;
        vecs[5].nwords = 2; vecs[5].addr = 32'h7; vecs[5].ack_delay = 3; vecs[5].exp_stb = 4;
        vecs[5].rx[0] = 8'h5A; vecs[5].rx[1] = 8'hA5;
        vecs[5].exp_adr[0] = 30'h1; vecs[5].exp_adr[1] = 30'h2;
        vecs[5].exp_sel[0] = 4'h8; vecs[5].exp_sel[1] = 4'h1;
        vecs[5].exp_dat[0] = 32'h5A000000; vecs[5].exp_dat[1] = 32'h000000A5;

        vecs[6] = blank("rd_wrap"); vecs[6].wsize = 2'd3; vecs[6].aincr = 1'b1; vecs[6].size = 8'd1;
        vecs[6].nwords = 2; vecs[6].addr = 32'hFFFFFFFC;
        vecs[6].rdata[0] = 32'h11223344; vecs[6].rdata[1] = 32'h55667788;
        vecs[6].exp_adr[0] = 30'h3FFFFFFF; vecs[6].exp_adr[1] = 30'h0;
        vecs[6].exp_sel[0] = 4'hF; vecs[6].exp_sel[1] = 4'hF;
        vecs[6].exp_tx[0] = 8'h44; vecs[6].exp_tx[1] = 8'h33; vecs[6].exp_tx[2] = 8'h22; vecs[6].exp_tx[3] = 8'h11;
        vecs[6].exp_tx[4] = 8'h88; vecs[6].exp_tx[5] = 8'h77; vecs[6].exp_tx[6] = 8'h66; vecs[6].exp_tx[7] = 8'h55;
        vecs[6].ntx = 8;

        vecs[7] = blank("wr_256_words"); vecs[7].wr = 1'b1; vecs[7].aincr = 1'b1; vecs[7].size = 8'd255;
        vecs[7].nwords = 256;
        for (int i = 0; i < 8; i++) vecs[7].rx[i] = 8'(i);
        vecs[7].exp_sel[0] = 4'h1; vecs[7].exp_sel[1] = 4'h2; vecs[7].exp_sel[2] = 4'h4; vecs[7].exp_sel[3] = 4'h8;
        vecs[7].exp_dat[0] = 32'h00000000; vecs[7].exp_dat[1] = 32'h00000100;
        vecs[7].exp_dat[2] = 32'h00020000; vecs[7].exp_dat[3] = 32'h03000000;

        repeat (3) @(negedge clk);
        chk("rst cyc", 32'(wb_cyc), 32'd0);
        chk("rst stb", 32'(wb_stb), 32'd0);
        chk("rst we_sel", {27'd0, wb_we, wb_sel}, 32'd0);
        chk("rst adr", 32'(wb_adr), 32'd0);
        chk("rst dat", wb_dat_o, 32'd0);
        chk("rst streams", {22'd0, rx_ready, tx_valid, tx_data}, 32'd0);
        chk("rst ready_err", {30'd0, mreq_ready, err_timeout}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Address wrap, then reset while the second word is on the bus.
        @(negedge clk);
        mreq_valid = 1'b1; mreq_wr = 1'b0; mreq_wsize = 2'd2; mreq_aincr = 1'b1;
        mreq_size = 8'd1; mreq_addr = 32'hFFFFFFFC; tx_ready = 1'b1;
        @(negedge clk);
        mreq_valid = 1'b0;
        chk("wrap stb0", 32'(wb_stb), 32'd1);
        chk("wrap adr0", 32'(wb_adr), 32'h3FFFFFFF);
        wb_ack = 1'b1; wb_dat_i = 32'hCAFEF00D;
        @(negedge clk);
        wb_ack = 1'b0;
        txn = 0;
        for (int i = 0; i < 50; i++) begin
            if (wb_stb) break;
            if (tx_valid) txn++;
            @(negedge clk);
        end
        chk("wrap tx_count", 32'(txn), 32'd4);
        chk("wrap stb1", 32'(wb_stb), 32'd1);
        chk("wrap adr1", 32'(wb_adr), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
        rdy = 0;
        for (int i = 0; i < 10; i++) begin
            if (mreq_ready) rdy++;
            @(negedge clk);
        end
        chk("midrst no_ready", 32'(rdy), 32'd0);
        chk("midrst idle_bus", {30'd0, wb_stb, tx_valid}, 32'd0);

        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
